// File: rtl/eth_stream_pkg.sv
// eth_stream_pkg
// Shared definitions for the receive-path streaming stages: the FCS and
// minimum-frame byte counts, the FCS strip state encoding and a helper that
// turns a "bytes minus one" keep field into a byte count.
package eth_stream_pkg;

  localparam int FCS_BYTES              = 4;
  localparam int ETH_MIN_STRIPPED_BYTES = 60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // keep carries "valid bytes minus one" on the last beat of a frame.
  function automatic logic [31:0] keep_to_bytes(input logic [31:0] keep);
    return keep + 32'd1;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_strip.sv
// eth_rx_fcs_strip
// Removes the trailing 4-byte FCS from a received frame stream and
// regenerates last/keep for the shortened frame. Valid-only stream, no
// backpressure. Every beat is held until the next beat of its frame shows up,
// because only then is it known whether the held beat ends the frame.
//
// Ports:
//   i_clk, i_rst            clock; asynchronous active-high reset
//   i_eths_slave_*          input stream (data, keep, valid, abort, last);
//                           last beat still includes the FCS
//   o_eths_master_*         output stream with the FCS removed; all outputs
//                           registered; keep is W-1 on non-last beats
//
// Optional build macro: ETH_RX_FCS_STRIP_RUNT_CHECK_EN
//   When defined, a saturating per-frame byte counter turns the last beat of
//   any frame shorter than 60 stripped bytes into an abort pulse.
module eth_rx_fcs_strip
  import eth_stream_pkg::*;
#(
  parameter int DATAPATH_WIDTH = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [DATAPATH_WIDTH-1:0]            i_eths_slave_data,
  input  logic [$clog2(DATAPATH_WIDTH/8)-1:0]  i_eths_slave_keep,
  input  logic                                 i_eths_slave_valid,
  input  logic                                 i_eths_slave_abort,
  input  logic                                 i_eths_slave_last,
  output logic [DATAPATH_WIDTH-1:0]            o_eths_master_data,
  output logic [$clog2(DATAPATH_WIDTH/8)-1:0]  o_eths_master_keep,
  output logic                                 o_eths_master_valid,
  output logic                                 o_eths_master_abort,
  output logic                                 o_eths_master_last
);

  localparam int W  = DATAPATH_WIDTH / 8;
  localparam int KW = $clog2(W);

  state_t                  state_reg, state_next;
  logic [DATAPATH_WIDTH-1:0] hold_data_reg, hold_data_next;
  logic [KW-1:0]           hold_keep_reg, hold_keep_next;
  logic                    started_reg, started_next;

  logic [DATAPATH_WIDTH-1:0] out_data_reg, out_data_next;
  logic [KW-1:0]           out_keep_reg, out_keep_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    out_abort_reg, out_abort_next;
  logic                    out_last_reg, out_last_next;

  logic [31:0]             in_bytes;

`ifdef ETH_RX_FCS_STRIP_RUNT_CHECK_EN
  logic [15:0]             byte_cnt_reg, byte_cnt_next;
  logic [16:0]             byte_sum;
`endif

  assign in_bytes = keep_to_bytes(32'(i_eths_slave_keep));

  always_comb begin
    state_next     = state_reg;
    hold_data_next = hold_data_reg;
    hold_keep_next = hold_keep_reg;
    started_next   = started_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_valid_next = 1'b0;
    out_abort_next = 1'b0;
    out_last_next  = 1'b0;

    // The pending final beat of the previous frame leaves unconditionally;
    // this cycle's input is then treated as the start of a new frame.
    if (state_reg == FLUSH) begin
      out_valid_next = 1'b1;
      out_last_next  = 1'b1;
      out_data_next  = hold_data_reg;
      out_keep_next  = hold_keep_reg;
      state_next     = IDLE;
      started_next   = 1'b0;
    end

    if (i_eths_slave_abort) begin
      // Only a frame that already put beats on the output needs an abort
      // downstream; in FLUSH the abort belongs to a frame not yet emitted.
      if (state_reg == HOLD && started_reg) begin
        out_abort_next = 1'b1;
      end
      hold_data_next = '0;
      hold_keep_next = '0;
      state_next     = IDLE;
      started_next   = 1'b0;
    end else if (i_eths_slave_valid) begin
      if (state_reg == HOLD) begin
        if (!i_eths_slave_last) begin
          out_valid_next = 1'b1;
          out_data_next  = hold_data_reg;
          out_keep_next  = KW'(W - 1);
          hold_data_next = i_eths_slave_data;
          started_next   = 1'b1;
        end else if (in_bytes <= 32'(FCS_BYTES)) begin
          // Current beat is all FCS; the FCS also eats the top
          // (FCS_BYTES - n) bytes of the held beat.
          out_valid_next = 1'b1;
          out_last_next  = 1'b1;
          out_data_next  = hold_data_reg;
          out_keep_next  = KW'(32'(W - FCS_BYTES - 1) + in_bytes);
          state_next     = IDLE;
          started_next   = 1'b0;
        end else begin
          // Frame ends inside the current beat: held beat goes out full and
          // the current one needs one more cycle as the final beat.
          out_valid_next = 1'b1;
          out_data_next  = hold_data_reg;
          out_keep_next  = KW'(W - 1);
          hold_data_next = i_eths_slave_data;
          hold_keep_next = KW'(in_bytes - 32'(FCS_BYTES + 1));
          state_next     = FLUSH;
          started_next   = 1'b1;
        end
      end else if (!i_eths_slave_last) begin
        hold_data_next = i_eths_slave_data;
        state_next     = HOLD;
        started_next   = 1'b0;
      end
      // A single-beat frame is nothing but FCS and is dropped.
    end

`ifdef ETH_RX_FCS_STRIP_RUNT_CHECK_EN
    byte_cnt_next = byte_cnt_reg;
    byte_sum      = 17'(byte_cnt_reg) +
                    (out_last_next ? (17'(out_keep_next) + 17'd1) : 17'(W));
    if (out_valid_next) begin
      if (out_last_next) begin
        byte_cnt_next = '0;
        if (byte_sum < 17'(ETH_MIN_STRIPPED_BYTES)) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
          out_abort_next = 1'b1;
        end
      end else begin
        byte_cnt_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
      end
    end else if (out_abort_next) begin
      byte_cnt_next = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      hold_data_reg <= '0;
      hold_keep_reg <= '0;
      started_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_abort_reg <= 1'b0;
      out_last_reg  <= 1'b0;
`ifdef ETH_RX_FCS_STRIP_RUNT_CHECK_EN
      byte_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      hold_data_reg <= hold_data_next;
      hold_keep_reg <= hold_keep_next;
      started_reg   <= started_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_valid_reg <= out_valid_next;
      out_abort_reg <= out_abort_next;
      out_last_reg  <= out_last_next;
`ifdef ETH_RX_FCS_STRIP_RUNT_CHECK_EN
      byte_cnt_reg  <= byte_cnt_next;
`endif
    end
  end

  assign o_eths_master_data  = out_data_reg;
  assign o_eths_master_keep  = out_keep_reg;
  assign o_eths_master_valid = out_valid_reg;
  assign o_eths_master_abort = out_abort_reg;
  assign o_eths_master_last  = out_last_reg;

endmodule

// File: tb/tb_eth_rx_fcs_strip.sv
// tb_eth_rx_fcs_strip
// Directed bench for eth_rx_fcs_strip: a 32-bit instance for most scenarios
// and a 64-bit instance for the FLUSH / back-to-back path. Output beats are
// captured on the falling edge into queues and compared with hand-derived
// beat counts, keep values and a byte-pattern model of the frame contents.
module tb_eth_rx_fcs_strip;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic [31:0] d4 = '0;
  logic [1:0]  k4 = '0;
  logic        v4 = 1'b0, a4 = 1'b0, l4 = 1'b0;
  logic [31:0] od4;
  logic [1:0]  ok4;
  logic        ov4, oa4, ol4;

  logic [63:0] d8 = '0;
  logic [2:0]  k8 = '0;
  logic        v8 = 1'b0, a8 = 1'b0, l8 = 1'b0;
  logic [63:0] od8;
  logic [2:0]  ok8;
  logic        ov8, oa8, ol8;

  eth_rx_fcs_strip #(.DATAPATH_WIDTH(32)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_eths_slave_data(d4), .i_eths_slave_keep(k4), .i_eths_slave_valid(v4),
    .i_eths_slave_abort(a4), .i_eths_slave_last(l4),
    .o_eths_master_data(od4), .o_eths_master_keep(ok4), .o_eths_master_valid(ov4),
    .o_eths_master_abort(oa4), .o_eths_master_last(ol4)
  );

  eth_rx_fcs_strip #(.DATAPATH_WIDTH(64)) dut8 (
    .i_clk(clk), .i_rst(rst),
    .i_eths_slave_data(d8), .i_eths_slave_keep(k8), .i_eths_slave_valid(v8),
    .i_eths_slave_abort(a8), .i_eths_slave_last(l8),
    .o_eths_master_data(od8), .o_eths_master_keep(ok8), .o_eths_master_valid(ov8),
    .o_eths_master_abort(oa8), .o_eths_master_last(ol8)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  keep;
    logic        valid;
    logic        last;
    logic        abort;
  } ev_t;

  ev_t q4[$];
  ev_t q8[$];
  ev_t e4, e8;
  int  errors = 0;
  int  checks = 0;

  always @(negedge clk) begin
    if (ov4 || oa4) begin
      e4 = '{data: {32'h0, od4}, keep: {1'b0, ok4}, valid: ov4, last: ol4, abort: oa4};
      q4.push_back(e4);
    end
    if (ov8 || oa8) begin
      e8 = '{data: od8, keep: ok8, valid: ov8, last: ol8, abort: oa8};
      q8.push_back(e8);
    end
  end

  // Frame byte i of a frame with a given seed.
  function automatic logic [7:0] fb(input int seed, input int i);
    return 8'(seed + i);
  endfunction

  function automatic logic [63:0] word(input int seed, input int beat, input int w);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) r[8*j +: 8] = fb(seed, beat * w + j);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic send4(input int len, input int seed, input bit gap);
    int nb;
    logic [63:0] t;
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      if (gap && (b % 3 == 2)) tick();
      t  = word(seed, b, 4);
      d4 = t[31:0];
      l4 = (b == nb - 1);
      k4 = (b == nb - 1) ? 2'((len - 1) % 4) : 2'd3;
      v4 = 1'b1;
      tick();
      v4 = 1'b0;
      l4 = 1'b0;
    end
  endtask

  task automatic send8(input int len, input int seed);
    int nb;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      d8 = word(seed, b, 8);
      l8 = (b == nb - 1);
      k8 = (b == nb - 1) ? 3'((len - 1) % 8) : 3'd7;
      v8 = 1'b1;
      tick();
      v8 = 1'b0;
      l8 = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ov4); end
    checks++;
    if (od4 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", od4); end
    checks++;
    if (ok4 !== 2'd0) begin errors++; $display("FAIL reset_keep: got %0d want 0", ok4); end
    checks++;
    if (ol4 !== 1'b0 || oa4 !== 1'b0) begin
      errors++; $display("FAIL reset_last_abort: got %0b/%0b want 0/0", ol4, oa4);
    end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_frame4(input string name, input int len, input int seed,
                             input bit gap, input int exp_beats, input int exp_keep);
    logic [31:0] exp, mask;
    int nbytes;
    bit islast;
    q4.delete();
    send4(len, seed, gap);
    drain();
    checks++;
    if (q4.size() != exp_beats) begin
      errors++; $display("FAIL %s beat_count: got %0d want %0d", name, q4.size(), exp_beats);
    end
    for (int b = 0; b < q4.size() && b < exp_beats; b++) begin
      islast = (b == exp_beats - 1);
      nbytes = islast ? exp_keep + 1 : 4;
      mask   = '0;
      for (int j = 0; j < nbytes; j++) mask[8*j +: 8] = 8'hFF;
      exp    = 32'(word(seed, b, 4));
      checks++;
      if (q4[b].valid !== 1'b1 || q4[b].abort !== 1'b0 || q4[b].last !== islast ||
          q4[b].keep !== 3'(islast ? exp_keep : 3) || ((q4[b].data[31:0] ^ exp) & mask) !== 0) begin
        errors++;
        $display("FAIL %s beat%0d: got v%0b a%0b l%0b k%0d d=%h want v1 a0 l%0b k%0d d=%h",
                 name, b, q4[b].valid, q4[b].abort, q4[b].last, q4[b].keep,
                 q4[b].data[31:0], islast, islast ? exp_keep : 3, exp);
      end
    end
    $display("test_frame4 %s: len=%0d beats_out=%0d", name, len, q4.size());
  endtask

  task automatic test_back_to_back();
    int fr, beat, seed, nout;
    bit islast;
    int kexp;
    logic [63:0] exp, mask;
    q8.delete();
    send8(70, 1);
    send8(64, 100);
    drain();
    checks++;
    if (q8.size() != 17) begin
      errors++; $display("FAIL b2b beat_count: got %0d want 17", q8.size());
    end
    for (int i = 0; i < q8.size() && i < 17; i++) begin
      fr     = (i < 9) ? 0 : 1;
      beat   = (fr == 0) ? i : i - 9;
      seed   = (fr == 0) ? 1 : 100;
      nout   = (fr == 0) ? 9 : 8;
      kexp   = (fr == 0) ? 1 : 3;
      islast = (beat == nout - 1);
      mask   = '0;
      for (int j = 0; j < (islast ? kexp + 1 : 8); j++) mask[8*j +: 8] = 8'hFF;
      exp    = word(seed, beat, 8);
      checks++;
      if (q8[i].valid !== 1'b1 || q8[i].abort !== 1'b0 || q8[i].last !== islast ||
          q8[i].keep !== 3'(islast ? kexp : 7) || ((q8[i].data ^ exp) & mask) !== 0) begin
        errors++;
        $display("FAIL b2b beat%0d: got l%0b k%0d d=%h want l%0b k%0d d=%h",
                 i, q8[i].last, q8[i].keep, q8[i].data, islast, islast ? kexp : 7, exp);
      end
    end
    $display("test_back_to_back: beats_out=%0d", q8.size());
  endtask

  task automatic test_abort();
    int nv, na, nl;
    logic [63:0] t;
    // Abort riding on the 4th beat of a frame already partly emitted.
    q4.delete();
    for (int b = 0; b < 4; b++) begin
      t = word(7, b, 4); d4 = t[31:0]; k4 = 2'd3; v4 = 1'b1; a4 = (b == 3);
      tick();
    end
    v4 = 1'b0; a4 = 1'b0;
    drain();
    nv = 0; na = 0; nl = 0;
    foreach (q4[i]) begin
      if (q4[i].valid) nv++;
      if (q4[i].abort) na++;
      if (q4[i].last) nl++;
    end
    checks++;
    if (nv != 2 || na != 1 || nl != 0) begin
      errors++; $display("FAIL abort_beat4: got valid=%0d abort=%0d last=%0d want 2/1/0", nv, na, nl);
    end
    checks++;
    if (q4.size() == 3 && (q4[2].abort !== 1'b1 || q4[2].valid !== 1'b0)) begin
      errors++; $display("FAIL abort_beat4_order: got a%0b v%0b want a1 v0", q4[2].abort, q4[2].valid);
    end
    // Abort on the first beat: nothing emitted.
    q4.delete();
    d4 = 32'h1111_1111; k4 = 2'd3; v4 = 1'b1; a4 = 1'b1; tick();
    v4 = 1'b0; a4 = 1'b0; drain();
    checks++;
    if (q4.size() != 0) begin errors++; $display("FAIL abort_beat1: got %0d events want 0", q4.size()); end
    // Abort on the second beat: first beat only held, never emitted.
    q4.delete();
    d4 = 32'h2222_2222; v4 = 1'b1; tick();
    d4 = 32'h3333_3333; a4 = 1'b1; tick();
    v4 = 1'b0; a4 = 1'b0; drain();
    checks++;
    if (q4.size() != 0) begin errors++; $display("FAIL abort_beat2: got %0d events want 0", q4.size()); end
    // Single-beat frame is pure FCS.
    q4.delete();
    d4 = 32'h4444_4444; k4 = 2'd3; l4 = 1'b1; v4 = 1'b1; tick();
    v4 = 1'b0; l4 = 1'b0; drain();
    checks++;
    if (q4.size() != 0) begin errors++; $display("FAIL single_beat: got %0d events want 0", q4.size()); end
    $display("test_abort done");
  endtask

  task automatic test_runt();
    int nv, na, nl;
    q4.delete();
    send4(40, 9, 1'b0);
    drain();
    nv = 0; na = 0; nl = 0;
    foreach (q4[i]) begin
      if (q4[i].valid) nv++;
      if (q4[i].abort) na++;
      if (q4[i].last) nl++;
    end
`ifdef ETH_RX_FCS_STRIP_RUNT_CHECK_EN
    checks++;
    if (nv != 8 || na != 1 || nl != 0) begin
      errors++; $display("FAIL runt40: got valid=%0d abort=%0d last=%0d want 8/1/0", nv, na, nl);
    end
`else
    checks++;
    if (nv != 9 || na != 0 || nl != 1) begin
      errors++; $display("FAIL runt40: got valid=%0d abort=%0d last=%0d want 9/0/1", nv, na, nl);
    end
    checks++;
    if (q4.size() == 9 && (q4[8].last !== 1'b1 || q4[8].keep !== 3'd3)) begin
      errors++; $display("FAIL runt40_last: got l%0b k%0d want l1 k3", q4[8].last, q4[8].keep);
    end
`endif
    $display("test_runt: valid=%0d abort=%0d last=%0d", nv, na, nl);
  endtask

  task automatic test_reset_mid();
    logic [63:0] t;
    for (int b = 0; b < 5; b++) begin
      t = word(3, b, 4); d4 = t[31:0]; k4 = 2'd3; v4 = 1'b1;
      tick();
    end
    v4 = 1'b0;
    checks++;
    if (ov4 !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %0b want 1", ov4); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ov4 !== 1'b0 || od4 !== 32'h0 || ok4 !== 2'd0 || ol4 !== 1'b0 || oa4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got v%0b d=%h k%0d l%0b a%0b want all zero", ov4, od4, ok4, ol4, oa4);
    end
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    drain();
    checks++;
    if (q4.size() != 0) begin errors++; $display("FAIL post_rst_quiet: got %0d events want 0", q4.size()); end
    test_frame4("post_rst64", 64, 50, 1'b0, 15, 3);
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_frame4("frame64", 64, 16, 1'b0, 15, 3);
    test_frame4("frame65", 65, 32, 1'b0, 16, 0);
    test_frame4("frame64_gaps", 64, 64, 1'b1, 15, 3);
    test_back_to_back();
    test_abort();
    test_frame4("after_abort64", 64, 80, 1'b0, 15, 3);
    test_runt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
